// File: rtl/mio_arbiter.sv
// Two-master round-robin arbiter for the shared memory/IO bus.
// Per-grant burst limit under contention, slave-stall timeout with abort.
module mio_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [31:0] m0_a,
  input  logic [31:0] m1_a,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic        m0_re,
  input  logic        m1_re,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_a,
  output logic [31:0] d_t_mem,
  output logic        wmem,
  output logic        rmem,
  input  logic [31:0] d_f_mem,
  input  logic        bus_rdy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GNT0 = 2'd1;
  localparam logic [1:0] S_GNT1 = 2'd2;

  localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic        g0, g1, gx;
  logic [31:0] sel_a, sel_wdata;
  logic        sel_we, sel_re, sel_req, oth_req;
  logic        stb, ack, tmo, rel;
  logic [4:0]  bcnt_inc;
  logic        enter, enter_m;

  assign g0 = (state_q == S_GNT0);
  assign g1 = (state_q == S_GNT1);
  assign gx = g0 | g1;

  assign sel_a     = g1 ? m1_a     : m0_a;
  assign sel_wdata = g1 ? m1_wdata : m0_wdata;
  assign sel_we    = g1 ? m1_we    : m0_we;
  assign sel_re    = g1 ? m1_re    : m0_re;
  assign sel_req   = g1 ? m1_req   : m0_req;
  assign oth_req   = g1 ? m0_req   : m1_req;

  assign stb      = gx & (sel_we | sel_re);
  assign ack      = stb & bus_rdy;
  assign tmo      = stb & ~bus_rdy & (tcnt_q == TMO_LAST);
  assign bcnt_inc = {1'b0, bcnt_q} + 5'd1;

  // Burst limit only forces a handover when the other master is waiting.
  assign rel = gx & (~sel_req | (ack & (bcnt_inc >= BURST_LIM) & oth_req) | tmo);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    enter   = 1'b0;
    enter_m = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m0_req | m1_req) begin
          enter   = 1'b1;
          enter_m = (m0_req & m1_req) ? ~last_q : m1_req;
        end
      end
      S_GNT0, S_GNT1: begin
        if (rel) begin
          if (oth_req) begin
            enter   = 1'b1;
            enter_m = g0;
          end else begin
            state_d = S_IDLE;
            bcnt_d  = 4'd0;
            tcnt_d  = 8'd0;
          end
        end else if (ack) begin
          bcnt_d = (bcnt_q == 4'hF) ? 4'hF : bcnt_q + 4'd1;
          tcnt_d = 8'd0;
        end else if (stb) begin
          tcnt_d = tcnt_q + 8'd1;
        end else begin
          tcnt_d = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter) begin
      state_d = enter_m ? S_GNT1 : S_GNT0;
      last_d  = enter_m;
      bcnt_d  = 4'd0;
      tcnt_d  = 8'd0;
    end
  end

  // last resets to 1 so m0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      bcnt_q  <= 4'd0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign m0_gnt   = g0;
  assign m1_gnt   = g1;
  assign m0_ack   = ack & g0;
  assign m1_ack   = ack & g1;
  assign m0_err   = tmo & g0;
  assign m1_err   = tmo & g1;
  assign m0_rdata = d_f_mem;
  assign m1_rdata = d_f_mem;

  assign mem_a   = gx ? sel_a     : 32'd0;
  assign d_t_mem = gx ? sel_wdata : 32'd0;
  assign wmem    = gx & sel_we;
  assign rmem    = gx & sel_re & ~sel_we;

endmodule

// File: tb/tb_mio_arbiter.sv
// Self-checking bench for mio_arbiter: directed scenarios plus a randomized
// run compared each cycle against a behavioural ownership model.
module tb_mio_arbiter;

  localparam int MB = 4;
  localparam int TO = 15;

  logic        clk;
  logic        rst_n;
  logic        m_req [2];
  logic [31:0] m_a   [2];
  logic [31:0] m_wd  [2];
  logic        m_we  [2];
  logic        m_re  [2];
  logic [31:0] d_f_mem;
  logic        bus_rdy;

  logic        m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata, mem_a, d_t_mem;
  logic        wmem, rmem;

  int checks = 0;
  int errors = 0;

  mio_arbiter #(.MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m_req[0]), .m1_req(m_req[1]),
    .m0_a(m_a[0]), .m1_a(m_a[1]),
    .m0_wdata(m_wd[0]), .m1_wdata(m_wd[1]),
    .m0_we(m_we[0]), .m1_we(m_we[1]),
    .m0_re(m_re[0]), .m1_re(m_re[1]),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_err(m0_err), .m1_err(m1_err),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_a(mem_a), .d_t_mem(d_t_mem),
    .wmem(wmem), .rmem(rmem),
    .d_f_mem(d_f_mem), .bus_rdy(bus_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the bus, who owned it last, how many
  // transactions finished in this ownership, how long the current stall is.
  logic [1:0] own;   // 0/1 = master index, 2 = nobody
  logic       lst;
  int         done;
  int         stall;

  logic [1:0]  e_gnt, e_ack, e_err;
  logic [31:0] e_a, e_d;
  logic        e_w, e_r, e_leave, idle_pick;

  assign idle_pick = (m_req[0] && m_req[1]) ? ~lst : m_req[1];

  always_comb begin
    e_gnt = '0; e_ack = '0; e_err = '0;
    e_a = '0; e_d = '0; e_w = 1'b0; e_r = 1'b0; e_leave = 1'b0;
    if (own != 2'd2) begin
      e_gnt[own[0]] = 1'b1;
      e_a = m_a[own[0]];
      e_d = m_wd[own[0]];
      e_w = m_we[own[0]];
      e_r = m_re[own[0]] & ~m_we[own[0]];
      if (m_we[own[0]] || m_re[own[0]]) begin
        if (bus_rdy) e_ack[own[0]] = 1'b1;
        else if (stall == TO - 1) e_err[own[0]] = 1'b1;
      end
      e_leave = !m_req[own[0]] ||
                (e_ack[own[0]] && (done + 1 >= MB) && m_req[~own[0]]) ||
                e_err[own[0]];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own <= 2'd2; lst <= 1'b1; done <= 0; stall <= 0;
    end else if (own == 2'd2) begin
      if (m_req[0] || m_req[1]) begin
        own <= {1'b0, idle_pick}; lst <= idle_pick; done <= 0; stall <= 0;
      end
    end else if (e_leave) begin
      if (m_req[~own[0]]) begin
        own <= {1'b0, ~own[0]}; lst <= ~own[0];
      end else begin
        own <= 2'd2;
      end
      done <= 0; stall <= 0;
    end else if (|e_ack) begin
      done <= (done >= 15) ? 15 : done + 1;
      stall <= 0;
    end else if (m_we[own[0]] || m_re[own[0]]) begin
      stall <= stall + 1;
    end else begin
      stall <= 0;
    end
  end

  logic [135:0] act_v, exp_v;
  assign act_v = {m1_gnt, m0_gnt, m1_ack, m0_ack, m1_err, m0_err,
                  m0_rdata, m1_rdata, mem_a, d_t_mem, wmem, rmem};
  assign exp_v = {e_gnt, e_ack, e_err, d_f_mem, d_f_mem, e_a, e_d, e_w, e_r};

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 1'b0; m_a[i] = '0; m_wd[i] = '0; m_we[i] = 1'b0; m_re[i] = 1'b0;
    end
    d_f_mem = '0;
    bus_rdy = 1'b1;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    m_req[0] = 1'b1; m_req[1] = 1'b1; m_we[0] = 1'b1; m_re[1] = 1'b1;
    m_a[0] = 32'hDEAD_BEEF; m_wd[0] = 32'h1111_2222;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err, wmem, rmem} !== 8'h00 ||
          mem_a !== 32'd0 || d_t_mem !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d got gnt=%b%b wmem=%b rmem=%b mem_a=%h want all 0",
                 k, m0_gnt, m1_gnt, wmem, rmem, mem_a);
      end
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    m_req[0] = 1'b1; m_we[0] = 1'b1; m_a[0] = 32'h0000_0804; m_wd[0] = 32'h0000_1234;
    bus_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b0 || wmem !== 1'b0) begin
      errors++;
      $display("FAIL single_cyc0 got gnt=%b wmem=%b want 0 0", m0_gnt, wmem);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || wmem !== 1'b1 || m0_ack !== 1'b1 ||
        mem_a !== 32'h0000_0804 || d_t_mem !== 32'h0000_1234) begin
      errors++;
      $display("FAIL single_cyc1 got gnt=%b wmem=%b ack=%b a=%h d=%h want 1 1 1 00000804 00001234",
               m0_gnt, wmem, m0_ack, mem_a, d_t_mem);
    end
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL single_vec got %h want %h", act_v, exp_v);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_burst_alternate();
    bit want0;
    do_reset();
    m_req[0] = 1'b1; m_req[1] = 1'b1; m_we[0] = 1'b1; m_we[1] = 1'b1;
    for (int k = 0; k < 26; k++) begin
      m_a[0] = 32'h1000 + k; m_a[1] = 32'h2000 + k;
      m_wd[0] = $urandom; m_wd[1] = $urandom;
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
          errors++;
          $display("FAIL burst_cyc0 got gnt=%b%b want 00", m0_gnt, m1_gnt);
        end
      end else begin
        want0 = (((k - 1) / MB) % 2) == 0;
        checks++;
        if (m0_gnt !== want0 || m1_gnt !== !want0 || wmem !== 1'b1 ||
            m0_ack !== want0 || m1_ack !== !want0) begin
          errors++;
          $display("FAIL burst_owner cyc %0d got gnt=%b%b ack=%b%b wmem=%b want m0=%b",
                   k, m0_gnt, m1_gnt, m0_ack, m1_ack, wmem, want0);
        end
      end
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL burst_vec cyc %0d got %h want %h", k, act_v, exp_v);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_read_m1();
    do_reset();
    m_req[1] = 1'b1; m_re[1] = 1'b1; m_a[1] = 32'hC000_0010;
    m_we[0] = 1'b1; m_a[0] = 32'h0000_0BAD;
    d_f_mem = 32'h0000_0041;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1 || m1_ack !== 1'b1 || m1_rdata !== 32'h41 || rmem !== 1'b1 ||
        wmem !== 1'b0 || mem_a !== 32'hC000_0010) begin
      errors++;
      $display("FAIL read_m1 got gnt=%b ack=%b rdata=%h rmem=%b wmem=%b a=%h want 1 1 41 1 0 c0000010",
               m1_gnt, m1_ack, m1_rdata, rmem, wmem, mem_a);
    end
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL read_vec got %h want %h", act_v, exp_v);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    m_req[0] = 1'b1; m_re[0] = 1'b1; m_a[0] = 32'h0000_4000;
    m_req[1] = 1'b1; m_we[1] = 1'b1; m_a[1] = 32'h0000_5000;
    bus_rdy = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 15) begin
        checks++;
        if (m0_gnt !== 1'b1 || m0_ack !== 1'b0 || m0_err !== (k == TO)) begin
          errors++;
          $display("FAIL timeout_m0 cyc %0d got gnt=%b ack=%b err=%b want 1 0 %b",
                   k, m0_gnt, m0_ack, m0_err, k == TO);
        end
      end
      if (k == TO + 1) begin
        checks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1 || m0_err !== 1'b0) begin
          errors++;
          $display("FAIL timeout_handover got gnt=%b%b err=%b want m0=0 m1=1 err=0",
                   m0_gnt, m1_gnt, m0_err);
        end
      end
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL timeout_vec cyc %0d got %h want %h", k, act_v, exp_v);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_req[1] = 1'b1; m_we[1] = 1'b1; m_re[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_a[1] = 32'h3000 + k;
      @(negedge clk);
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if (m1_gnt !== 1'b1 || wmem !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got gnt=%b wmem=%b want 1 1", m1_gnt, wmem);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m1_gnt !== 1'b0 || m0_gnt !== 1'b0 || wmem !== 1'b0 || rmem !== 1'b0 ||
        m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop got gnt=%b%b wmem=%b rmem=%b ack=%b want all 0",
               m0_gnt, m1_gnt, wmem, rmem, m1_ack);
    end
    m_req[0] = 1'b1; m_re[0] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_first got gnt=%b%b want m0=1 m1=0", m0_gnt, m1_gnt);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_both_strobes();
    do_reset();
    m_req[0] = 1'b1; m_we[0] = 1'b1; m_re[0] = 1'b1; m_a[0] = 32'h0000_0100;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (wmem !== 1'b1 || rmem !== 1'b0 || m0_ack !== 1'b1) begin
      errors++;
      $display("FAIL both_strobes got wmem=%b rmem=%b ack=%b want 1 0 1", wmem, rmem, m0_ack);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_random();
    int stall_left = 0;
    int bad = 0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(15) == 0) m_req[i] = ~m_req[i];
        m_we[i] = ($urandom_range(2) == 0);
        m_re[i] = ($urandom_range(2) == 0);
        m_a[i]  = $urandom;
        m_wd[i] = $urandom;
      end
      d_f_mem = $urandom;
      if (stall_left > 0) stall_left--;
      else if ($urandom_range(24) == 0) stall_left = $urandom_range(20);
      bus_rdy = (stall_left == 0) && ($urandom_range(5) != 0);
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_vec cyc %0d got %h want %h", k, act_v, exp_v);
        bad++;
      end
      checks++;
      if (m0_gnt === 1'b1 && m1_gnt === 1'b1) begin
        errors++;
        $display("FAIL random_dual_gnt cyc %0d", k);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_burst_alternate();
    test_read_m1();
    test_timeout();
    test_reset_mid();
    test_both_strobes();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mio_arbiter.md
# mio_arbiter

Two-master arbiter for the single memory/IO bus driven into `mio_bus`. It shares the bus between master 0 (CPU data port) and master 1 (block-transfer engine, e.g. VRAM scroll/clear). It uses round-robin grant with a per-grant burst limit and a slave-stall timeout. The granted master's address, data and strobes are muxed onto the bus, and it gets a per-transaction `ack` with returned read data.

## Interface
- `MAX_BURST`, 4: max transactions a master may complete per grant while the other master is requesting (1..15).
- `TIMEOUT`, 15: consecutive stalled cycles (`bus_rdy`=0 with a strobe active) before a transaction is aborted (1..255).

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  master requests bus ownership; held high while it wants the bus.
- `m0_a`, `m1_a`  in  32  transaction address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_we`, `m1_we`  in  1  write strobe (valid only while granted).
- `m0_re`, `m1_re`  in  1  read strobe (valid only while granted).
- `m0_gnt`, `m1_gnt`  out  1  registered grant; at most one high.
- `m0_ack`, `m1_ack`  out  1  transaction complete this cycle.
- `m0_err`, `m1_err`  out  1  one-cycle pulse, transaction aborted by timeout.
- `m0_rdata`, `m1_rdata`  out  32  read data, valid with `ack`.
- `mem_a`  out  32  bus address.
- `d_t_mem`  out  32  bus write data.
- `wmem`, `rmem`  out  1  bus write/read strobes.
- `d_f_mem`  in  32  bus read data.
- `bus_rdy`  in  1  slave completes the access this cycle (tie 1 for single-cycle slaves).

## Operation
- States: IDLE, GNT0, GNT1. Internal: `last` (1 bit, last master granted), `bcnt` (4 bits, completed transactions in current grant), `tcnt` (8 bits, stall counter).
- IDLE: only m0_req -> GNT0. Only m1_req -> GNT1. Both -> the master != `last`. Neither -> stay.
- Entering GNTx: `last`<=x, `bcnt`<=0, `tcnt`<=0.
- In GNTx, the bus carries master x: `mem_a`=mx_a, `d_t_mem`=mx_wdata, `wmem`=mx_we, `rmem`=mx_re & ~mx_we. Write wins if both strobes are set.
- Outside GNTx (IDLE or other grant): `mem_a`=0, `d_t_mem`=0, `wmem`=`rmem`=0. Non-granted master strobes are ignored.
- Completion: in GNTx, if a strobe is active and `bus_rdy`=1, then `mx_ack`=1 (combinational), `mx_rdata`=`d_f_mem`, `bcnt`++ (saturating at 15), `tcnt`<=0.
- Stall: if a strobe is active and `bus_rdy`=0, `tcnt`++. When `tcnt`==TIMEOUT-1 with a strobe active and `bus_rdy`=0:
  - `mx_err`=1 for that cycle, no `ack`.
  - The grant is released regardless of `req`.
- Release from GNTx at end of cycle, if any of the following holds:
  - mx_req=0;
  - `mx_ack`=1 and `bcnt`+1 >= MAX_BURST and the other master's `req`=1;
  - a timeout fires.
- On release: if the other master's `req`=1, go directly to GNTy (no idle bubble). Otherwise go to IDLE.
- A master dropping `req` with a strobe still high: the strobe is ignored from the next cycle. A transaction in flight without `bus_rdy` is abandoned, with no `ack`/`err`.
- `mx_rdata` outside `ack` = `d_f_mem` (don't-care for masters).

## Timing
- Reset (`rst_n`=0, async): state=IDLE, `last`=1 (so m0 wins the first contention), `bcnt`=`tcnt`=0. All `gnt`/`ack`/`err`=0, bus outputs 0. This also applies mid-transaction: strobes drop immediately.
- Grant latency:
  - `req` rising in cycle n (IDLE) -> `gnt` high in cycle n+1.
  - The first transaction may complete in n+1.
- Single-cycle slave: one `ack` per cycle while granted and strobing.
- Handover: the last `ack` of x in cycle n -> `my_gnt` high in n+1, `mx_gnt` low in n+1.
- `ack`/`err` depend combinationally on `bus_rdy`. `gnt` is registered only.
- Timeout: strobe asserted in cycle s with `bus_rdy` held 0 -> `err` in cycle s+TIMEOUT-1, grant dropped at s+TIMEOUT.

## Test plan
- Reset, m0_req=1, `bus_rdy`=1, m0_we=1 at `mem_a`=0x0000_0804, data 0x1234 -> m0_gnt at cycle 1, `wmem`=1, `mem_a`=0x804, m0_ack in cycle 1.
- Both req from reset, both strobing every cycle, MAX_BURST=4 -> m0 gets 4 acks, then m1 gets 4, alternating; gnt never both high; no idle cycle between grants.
- m1 read from 0xC000_0010, `d_f_mem`=0x41 -> m1_ack with m1_rdata=0x41. m0 with m0_we=1 but no grant -> `wmem`=0.
- m0 read with `bus_rdy`=0 held, TIMEOUT=15 -> m0_err pulse 14 cycles after strobe start, no ack, m0_gnt low next cycle, pending m1 granted.
- `rst_n` pulsed low mid-burst of m1 -> gnt, `wmem`, `rmem` drop immediately. After release with both req, m0 granted first.
- Both we and re set by m0 -> `wmem`=1, `rmem`=0.
